uart_tx: RTL and testbench

Asynchronous-serial (UART) transmitter. It serialises one 8-bit byte per request as: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. Bit time is set at run time by a clock divider. It sits between a host-side register interface and the TX pin. A request is edge-triggered: one frame per rising edge of write_i.

---
 rtl/uart_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx : asynchronous-serial transmitter
//
// Sends one 8-bit byte per rising edge of write_i as:
//   start(0), data[0..7] LSB first, optional parity, 1 or 2 stop bits(1).
// Every bit lasts D clock cycles, D = max(clock_divider_i, 1), latched when
// the request is accepted.
//
// Ports
//   clock_i          system clock, rising edge
//   reset_i          synchronous active-high reset
//   write_i          transmit request, a 0->1 transition starts one frame
//   two_stop_bits_i  1 = two stop bits, 0 = one
//   parity_bit_i     1 = append parity bit after the data
//   parity_even_i    1 = even parity, 0 = odd
//   clock_divider_i  bit period in clock cycles (0 behaves as 1)
//   data_i           byte to send
//   serial_o         TX line, idle high
//   busy_o           high during reset and while a frame is pending/running
//
// Handshake: a request is the rising edge of write_i seen at a clock edge.
// It is accepted only when the transmitter is idle and busy_o is low; the
// accepting edge latches data and configuration and raises busy_o. Requests
// arriving while busy_o is high are dropped, never queued. busy_o falls on
// the edge that ends the last stop bit.
// ---------------------------------------------------------------------------
module uart_tx (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        write_i,
   input  logic        two_stop_bits_i,
   input  logic        parity_bit_i,
   input  logic        parity_even_i,
   input  logic [15:0] clock_divider_i,
   input  logic [7:0]  data_i,
   output logic        serial_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_START_PENDING = 3'd1,
      ST_START         = 3'd2,
      ST_DATA          = 3'd3,
      ST_PARITY        = 3'd4,
      ST_STOP          = 3'd5
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic        write_q;
   logic [7:0]  data_q;
   logic        two_stop_q;
   logic        parity_en_q;
   logic        parity_even_q;
   logic [15:0] div_q;
   logic [15:0] baud_cnt_q;
   logic [2:0]  bit_idx_q;
   logic [2:0]  bit_idx_d;
   logic        stop_idx_q;

   logic        request;
   logic        accept;
   logic        bit_end;
   logic        in_bit_state;
   logic        parity_val;
   logic        serial_d;
   logic        busy_d;

   assign request      = write_i & ~write_q;
   assign accept       = request & (state_q == ST_IDLE) & ~busy_o;
   // Last cycle of the current bit period; only meaningful in bit states.
   assign bit_end      = (baud_cnt_q == (div_q - 16'd1));
   assign in_bit_state = (state_q == ST_START) || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_STOP);
   assign parity_val   = parity_even_q ? (^data_q) : ~(^data_q);
   // Index of the data bit that will be on the line after this edge.
   assign bit_idx_d    = ((state_q == ST_DATA) && bit_end) ? (bit_idx_q + 3'd1)
                                                           : bit_idx_q;

   // ---------------- state register and datapath ----------------
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         serial_o      <= 1'b1;
         busy_o        <= 1'b1;
         // Held at 1 so a write_i level present through reset is not an edge.
         write_q       <= 1'b1;
         data_q        <= 8'd0;
         two_stop_q    <= 1'b0;
         parity_en_q   <= 1'b0;
         parity_even_q <= 1'b0;
         div_q         <= 16'd1;
         baud_cnt_q    <= 16'd0;
         bit_idx_q     <= 3'd0;
         stop_idx_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         serial_o <= serial_d;
         busy_o   <= busy_d;
         write_q  <= write_i;

         if (accept) begin
            data_q        <= data_i;
            two_stop_q    <= two_stop_bits_i;
            parity_en_q   <= parity_bit_i;
            parity_even_q <= parity_even_i;
            div_q         <= (clock_divider_i == 16'd0) ? 16'd1 : clock_divider_i;
            bit_idx_q     <= 3'd0;
            stop_idx_q    <= 1'b0;
         end else begin
            bit_idx_q <= bit_idx_d;
            if ((state_q == ST_STOP) && bit_end) begin
               stop_idx_q <= 1'b1;
            end
         end

         if (in_bit_state && !bit_end) begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
         end else begin
            baud_cnt_q <= 16'd0;
         end
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_START_PENDING;
         end
         ST_START_PENDING: begin
            state_d = ST_START;
         end
         ST_START: begin
            if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end && (bit_idx_q == 3'd7)) begin
               state_d = parity_en_q ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (bit_end && (stop_idx_q || !two_stop_q)) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------- output logic ----------------
   // Outputs are registered: the values computed here describe the state
   // being entered, so serial_o/busy_o change on the same edge as the state.
   always_comb begin
      serial_d = 1'b1;
      busy_d   = (state_d != ST_IDLE);
      case (state_d)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = data_q[bit_idx_d];
         ST_PARITY: serial_d = parity_val;
         default:   serial_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset_i;
  logic        write_i;
  logic        two_stop_bits_i;
  logic        parity_bit_i;
  logic        parity_even_i;
  logic [15:0] clock_divider_i;
  logic [7:0]  data_i;
  logic        serial_o;
  logic        busy_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_tx dut (
    .clock_i         (clk),
    .reset_i         (reset_i),
    .write_i         (write_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .clock_divider_i (clock_divider_i),
    .data_i          (data_i),
    .serial_o        (serial_o),
    .busy_o          (busy_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  // Each entry is {busy, serial} expected after one clock edge.
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is a list of line levels, each held D cycles.
  task automatic push_bit(input logic b, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b1, b});
  endtask

  task automatic build_frame(input logic [7:0] data, input int d, input logic par,
                             input logic even, input logic two);
    int d_eff;
    int ones;
    d_eff = (d == 0) ? 1 : d;
    ones = 0;
    push_bit(1'b0, d_eff);
    for (int i = 0; i < 8; i++) begin
      push_bit(data[i], d_eff);
      ones += int'(data[i]);
    end
    if (par) push_bit(even ? logic'(ones % 2) : logic'(1 - (ones % 2)), d_eff);
    push_bit(1'b1, d_eff);
    if (two) push_bit(1'b1, d_eff);
  endtask

  // ---------------- driver tasks ----------------
  // disturb: mid-frame write_i toggles and inputs change; hold: leave write_i high.
  task automatic run_frame(input logic [7:0] data, input int d, input logic par,
                           input logic even, input logic two, input bit disturb,
                           input bit hold);
    logic [1:0] e;
    int n;
    write_i = 1'b0;
    @(negedge clk);
    data_i          = data;
    clock_divider_i = 16'(d);
    parity_bit_i    = par;
    parity_even_i   = even;
    two_stop_bits_i = two;
    write_i         = 1'b1;
    build_frame(data, d, par, even, two);
    @(negedge clk);
    chk("accept", {busy_o, serial_o}, 2'b11);
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("bit_d%0d_c%0d", d, n), {busy_o, serial_o}, e);
      if (disturb && n == 2) write_i = 1'b0;
      if (disturb && n == 4) begin
        write_i         = 1'b1;
        data_i          = ~data;
        clock_divider_i = 16'(d + 3);
        parity_bit_i    = ~par;
        parity_even_i   = ~even;
        two_stop_bits_i = ~two;
      end
      n++;
    end
    @(negedge clk);
    chk("done", {busy_o, serial_o}, 2'b01);
    if (!hold && !disturb) write_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_second", {busy_o, serial_o}, 2'b01);
    end
  endtask

  // Every rising edge of serial_o must occur while busy_o is high.
  logic prev_ser = 1'b1;
  always @(negedge clk) begin
    if (serial_o === 1'b1 && prev_ser === 1'b0) chk("rise_busy", {1'b0, busy_o}, 2'b01);
    prev_ser = serial_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_i         = 1'b1;
    write_i         = 1'b0;
    two_stop_bits_i = 1'b0;
    parity_bit_i    = 1'b0;
    parity_even_i   = 1'b0;
    clock_divider_i = 16'd1;
    data_i          = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset", {busy_o, serial_o}, 2'b11);
    reset_i = 1'b0;
    @(negedge clk);
    chk("reset_release", {busy_o, serial_o}, 2'b01);

    run_frame(8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8'hA3, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(8'hA3, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(8'h3C, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(8'h81, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a data bit, write_i held high through it
    write_i = 1'b0;
    @(negedge clk);
    data_i          = 8'($urandom);
    clock_divider_i = 16'd3;
    parity_bit_i    = 1'b0;
    two_stop_bits_i = 1'b0;
    write_i         = 1'b1;
    @(negedge clk);
    chk("mid_accept", {busy_o, serial_o}, 2'b11);
    repeat (11) @(negedge clk);
    chk("mid_busy", {busy_o, 1'b0}, 2'b10);
    reset_i = 1'b1;
    @(negedge clk);
    chk("mid_reset", {busy_o, serial_o}, 2'b11);
    reset_i = 1'b0;
    @(negedge clk);
    chk("mid_release", {busy_o, serial_o}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_frame", {busy_o, serial_o}, 2'b01);
    end
    run_frame(8'($urandom), 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_frame(8'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
                1'($urandom), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
